// File: rtl/key_event_decoder_pkg.sv
// Shared types and default timing for the key event decoder.
// State encodings are one-hot; the default counts assume a 50 MHz clock.
package key_evt_pkg;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        PRESS1    = 5'b00010,
        LONG_HOLD = 5'b00100,
        WAIT2     = 5'b01000,
        PRESS2    = 5'b10000
    } state_t;

    localparam int LONG_CNT_DEF = 50_000_000;  // 1 s hold
    localparam int DBL_CNT_DEF  = 15_000_000;  // 300 ms double-click gap

endpackage

// File: rtl/key_event_decoder_if.sv
// Debounced key in, gesture event pulses out; state is exported for observation.
// key_state is meaningful only in a cycle where key_flag=1 (0=pressed, 1=released).
interface key_event_decoder_if;
    import key_evt_pkg::*;

    logic   key_flag;
    logic   key_state;
    logic   short_press;
    logic   long_press;
    logic   double_click;
    logic   busy;
    state_t state;

    modport master (
        output key_flag, key_state,
        input  short_press, long_press, double_click, busy, state
    );

    modport slave (
        input  key_flag, key_state,
        output short_press, long_press, double_click, busy, state
    );

endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced key transitions into short-press, long-press and double-click pulses.
// Each gesture produces at most one registered, single-cycle event.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT = LONG_CNT_DEF,
    parameter int DBL_CNT  = DBL_CNT_DEF,
    parameter int CNT_W    = 26
) (
    input logic                clk,
    input logic                rst,
    key_event_decoder_if.slave evt
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             short_q;
    logic             long_q;
    logic             dbl_q;
    logic             press_ev;
    logic             release_ev;

    assign press_ev   = evt.key_flag & ~evt.key_state;
    assign release_ev = evt.key_flag &  evt.key_state;

    // Saturating increment so a stuck state can never wrap back into a match.
    assign timer_next = (timer == {CNT_W{1'b1}}) ? timer : timer + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (press_ev) begin
                        state <= PRESS1;
                    end
                end
                PRESS1: begin
                    // The hold timeout takes priority over a coincident release.
                    if (timer == LONG_LAST) begin
                        state  <= LONG_HOLD;
                        timer  <= '0;
                        long_q <= 1'b1;
                    end else if (release_ev) begin
                        state <= WAIT2;
                        timer <= '0;
                    end else begin
                        timer <= timer_next;
                    end
                end
                LONG_HOLD: begin
                    timer <= '0;
                    if (release_ev) begin
                        state <= IDLE;
                    end
                end
                WAIT2: begin
                    // A second press on the last window cycle still counts as a double click.
                    if (press_ev) begin
                        state <= PRESS2;
                        timer <= '0;
                    end else if (timer == DBL_LAST) begin
                        state   <= IDLE;
                        timer   <= '0;
                        short_q <= 1'b1;
                    end else begin
                        timer <= timer_next;
                    end
                end
                PRESS2: begin
                    timer <= '0;
                    if (release_ev) begin
                        state <= IDLE;
                        dbl_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign evt.short_press  = short_q;
    assign evt.long_press   = long_q;
    assign evt.double_click = dbl_q;
    assign evt.busy         = (state != IDLE);
    assign evt.state        = state;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CNT=20 and DBL_CNT=10.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_key_event_decoder;
    import key_evt_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_short;
    int   n_long;
    int   n_dbl;
    int   s0;
    int   l0;
    int   d0;

    key_event_decoder_if evt ();

    key_event_decoder #(
        .LONG_CNT (20),
        .DBL_CNT  (10),
        .CNT_W    (26)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .evt (evt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Event tally plus the one-event-per-cycle rule.
    always @(negedge clk) begin
        if (evt.short_press === 1'b1)  n_short++;
        if (evt.long_press === 1'b1)   n_long++;
        if (evt.double_click === 1'b1) n_dbl++;
        if ((evt.short_press | evt.long_press | evt.double_click) === 1'b1)
            check("one_event", 32'($countones({evt.short_press, evt.long_press, evt.double_click})), 32'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle key_flag pulse; returns 1 ns after the edge that consumed it.
    task automatic key_pulse(input logic lvl);
        evt.key_flag  = 1'b1;
        evt.key_state = lvl;
        tick(1);
        evt.key_flag  = 1'b0;
        evt.key_state = 1'b1;
    endtask

    task automatic snap();
        s0 = n_short;
        l0 = n_long;
        d0 = n_dbl;
    endtask

    task automatic check_counts(input string tag, input int es, input int el, input int ed);
        check({tag, "_short_cnt"}, 32'(n_short - s0), 32'(es));
        check({tag, "_long_cnt"},  32'(n_long - l0),  32'(el));
        check({tag, "_dbl_cnt"},   32'(n_dbl - d0),   32'(ed));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_errors = 0;
        n_short = 0; n_long = 0; n_dbl = 0;
        evt.key_flag  = 1'b0;
        evt.key_state = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("rst_state", 32'(evt.state), 32'(IDLE));
        check("rst_busy", 32'(evt.busy), 32'd0);
        check("rst_events", 32'({evt.short_press, evt.long_press, evt.double_click}), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Short press: release after 5, pulse 10 cycles after the release edge.
        snap();
        key_pulse(1'b0);
        check("sp_press_state", 32'(evt.state), 32'(PRESS1));
        check("sp_busy", 32'(evt.busy), 32'd1);
        tick(4);
        key_pulse(1'b1);
        check("sp_wait_state", 32'(evt.state), 32'(WAIT2));
        tick(9);
        check("sp_early", 32'(evt.short_press), 32'd0);
        check("sp_early_busy", 32'(evt.busy), 32'd1);
        tick(1);
        check("sp_pulse", 32'(evt.short_press), 32'd1);
        check("sp_busy_fall", 32'(evt.busy), 32'd0);
        tick(1);
        check("sp_pulse_end", 32'(evt.short_press), 32'd0);
        tick(12);
        check_counts("sp", 1, 0, 0);

        // Long press: pulse exactly 20 cycles after press, nothing on release.
        snap();
        key_pulse(1'b0);
        tick(19);
        check("lp_early", 32'(evt.long_press), 32'd0);
        check("lp_early_state", 32'(evt.state), 32'(PRESS1));
        tick(1);
        check("lp_pulse", 32'(evt.long_press), 32'd1);
        check("lp_hold_state", 32'(evt.state), 32'(LONG_HOLD));
        tick(1);
        check("lp_pulse_end", 32'(evt.long_press), 32'd0);
        tick(19);
        key_pulse(1'b1);
        check("lp_rel_state", 32'(evt.state), 32'(IDLE));
        check("lp_rel_busy", 32'(evt.busy), 32'd0);
        tick(12);
        check_counts("lp", 0, 1, 0);

        // Double click with a long second press.
        snap();
        key_pulse(1'b0);
        tick(4);
        key_pulse(1'b1);
        tick(3);
        key_pulse(1'b0);
        check("dc_press2_state", 32'(evt.state), 32'(PRESS2));
        tick(29);
        check("dc_no_early", 32'(evt.double_click), 32'd0);
        key_pulse(1'b1);
        check("dc_pulse", 32'(evt.double_click), 32'd1);
        check("dc_idle", 32'(evt.state), 32'(IDLE));
        tick(1);
        check("dc_pulse_end", 32'(evt.double_click), 32'd0);
        tick(12);
        check_counts("dc", 0, 0, 1);

        // Second press on the last window cycle (timer==9) beats the timeout.
        snap();
        key_pulse(1'b0);
        tick(4);
        key_pulse(1'b1);
        tick(9);
        key_pulse(1'b0);
        check("edge_state", 32'(evt.state), 32'(PRESS2));
        check("edge_no_short", 32'(evt.short_press), 32'd0);
        tick(2);
        key_pulse(1'b1);
        check("edge_dbl", 32'(evt.double_click), 32'd1);
        tick(12);
        check_counts("edge", 0, 0, 1);

        // Reset mid-press aborts the gesture silently.
        snap();
        key_pulse(1'b0);
        tick(9);
        rst_n = 1'b0;
        #1;
        check("ar_state", 32'(evt.state), 32'(IDLE));
        check("ar_busy", 32'(evt.busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(25);
        check("ar_still_idle", 32'(evt.state), 32'(IDLE));
        key_pulse(1'b1);
        check("ar_rel_idle", 32'(evt.state), 32'(IDLE));
        tick(12);
        check_counts("ar", 0, 0, 0);

        // Spurious release in IDLE and a duplicate press in PRESS1 are ignored.
        snap();
        key_pulse(1'b1);
        check("sp2_idle", 32'(evt.state), 32'(IDLE));
        key_pulse(1'b0);
        tick(2);
        key_pulse(1'b0);
        check("sp2_dup_press", 32'(evt.state), 32'(PRESS1));
        tick(2);
        key_pulse(1'b1);
        check("sp2_wait", 32'(evt.state), 32'(WAIT2));
        tick(12);
        check_counts("sp2", 1, 0, 0);
        check("final_idle", 32'(evt.state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
